alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
// Sequencer/arbiter that shares one single_ALU-style datapath (3-bit op, A, B -> result, zero) between two
// requesters. Adds a multi-cycle shift-right-by-N command (SRLN), built from repeated ALU srl-by-1 passes.
// Sits between the two requesters and the ALU instance; the ALU itself stays purely combinational.
// PARAMETERS
// WIDTH  32  operand/result width; must match the ALU.
// SHW    5   shift-count bits taken from A[SHW-1:0] for SRLN.
// PORTS
// clk          in   1      rising-edge clock
// rst_n        in   1      asynchronous, active-low reset
// reqN_valid   in   1      N=0,1: request present; held until accepted
// reqN_ready   out  1      N=0,1: accept strobe; transfer when valid&ready
// reqN_op      in   4      [3]=0: ALU op [2:0]; 4'b1101=SRLN; other [3]=1 codes reserved
// reqN_a       in   WIDTH  operand A (SRLN: shift count in [SHW-1:0])
// reqN_b       in   WIDTH  operand B (SRLN: value to shift)
// rspN_valid   out  1      N=0,1: one-cycle response pulse to the owner
// rspN_result  out  WIDTH  registered result; valid while rspN_valid=1
// rspN_zero    out  1      registered ALU zero flag of the final pass
// alu_op       out  3      to ALU operation
// alu_a        out  WIDTH  to ALU A
// alu_b        out  WIDTH  to ALU B
// alu_result   in   WIDTH  from ALU result
// alu_zero     in   1      from ALU zero
// BEHAVIOUR
// - Reset (async): state=IDLE; op/a/b/cnt/res regs=0; zero_reg=0; owner=0; last_grant=1;
//   all ready and rsp_valid=0; alu_op=3'b010, alu_a=alu_b=0.
// - FSM: IDLE -> EXEC -> RESP -> IDLE. One request in flight; no response back-pressure.
// - IDLE: grant to the sole valid requester; if both valid, grant !last_grant (req0 wins first after reset).
//   reqN_ready=1 only in IDLE and only for the granted N. On handshake, capture op/a/b,
//   set cnt=a[SHW-1:0], owner=N, last_grant=N -> EXEC.
// - EXEC, normal op: alu_op=op[2:0], alu_a=a_reg, alu_b=b_reg; latch alu_result/alu_zero -> RESP.
// - EXEC, reserved op: executed as add (3'b010).
// - EXEC, SRLN with cnt=0: pass-through alu_op=3'b001 (or), alu_a=0, alu_b=b_reg; latch -> RESP.
// - EXEC, SRLN with cnt>=1: alu_op=3'b101, alu_b=b_reg.
//   If cnt>1: b_reg<=alu_result, cnt<=cnt-1, stay in EXEC.
//   If cnt==1: latch result/zero -> RESP.
// - RESP: rsp[owner]_valid=1 for exactly one cycle; the other rsp_valid stays 0 -> IDLE.
// - Outside EXEC, ALU inputs idle at op=3'b010, a=b=0.
// - Latency: handshake at cycle T -> rsp_valid at T+1+max(n,1), where n=SRLN count; normal ops give T+2.
// - rspN_result/zero hold their last value between responses (rsp_valid qualifies).
// - Unsigned width rules follow the ALU: add/sub wrap mod 2^WIDTH; slt is unsigned.
// - A requester that drops valid before ready is ignored; no partial capture.
// - Reset mid-operation: transaction discarded, no response issued, FSM restarts in IDLE.
// STRUCTURE
// - Shared include (alu_defs.vh): ALU op localparams (AND=000, OR=001, ADD=010, XOR=011, NOR=100,
//   SRL=101, SUB=110, SLT=111), SRLN=4'b1101, FSM state encodings.
// - One sub-module, rr_arb2: two-request round-robin arbiter (inputs valid0/1, last_grant; outputs grant, gnt_valid).
// - Top level holds the FSM, operand/count registers and ALU drive mux; the bench instantiates the real ALU.
// TESTING
// 1. After reset, req0 ADD a=5 b=7 -> ready0 at T, rsp0_valid at T+2, result=12, zero=0; rsp1_valid stays 0.
// 2. req1 SUB a=9 b=9 -> rsp1_valid at T+2, result=0, zero=1; next SLT a=3 b=32'hFFFFFFFF -> result=1.
// 3. Both valid continuously, 4 ops each -> grants alternate 0,1,0,1...; no response lost or misrouted.
// 4. SRLN a=4 b=32'h80000000 -> rsp at T+5, result=32'h08000000;
//    a=0 -> rsp at T+2, result=b; a=32 -> count 0, result=b.
// 5. SRLN a=31 b=1 -> result=0, zero=1 at T+32; reserved op 4'b1000 a=2 b=3 -> result=5.
// 6. rst_n low during SRLN count=10 after 3 passes -> no rsp, outputs at reset values;
//    next req0 ADD completes normally at T+2.

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester ALU sharing controller:
// ALU operation codes, the extended SRLN command, FSM states and sizes.
package alu_share_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int SHIFT_BITS = 5;
  localparam int OP_WIDTH   = 4;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [OP_WIDTH-1:0] OP_SRLN = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // True for the multi-cycle shift-right-by-N command.
  function automatic logic is_srln(input logic [OP_WIDTH-1:0] op);
    return (op == OP_SRLN);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// One requester's link to the controller: request handshake plus the
// registered response returned to that requester.
interface alu_share_ctrl_if
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
);

  logic                valid;
  logic                ready;
  logic [OP_WIDTH-1:0] op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                rsp_valid;
  logic [WIDTH-1:0]    rsp_result;
  logic                rsp_zero;

  modport master (
    output valid, op, a, b,
    input  ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  valid, op, a, b,
    output ready, rsp_valid, rsp_result, rsp_zero
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, and when both
// ask at once the one that did not win last time gets the grant.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic gnt_valid
);

  // Pick the winner; grant is only meaningful while gnt_valid is high.
  always_comb begin
    gnt_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else begin
      grant = valid1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer that time-shares one combinational ALU between two requesters,
// one transaction at a time, and builds SRLN out of repeated srl-by-1 passes.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int SHW   = SHIFT_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_ctrl_if.slave  req0,
  alu_share_ctrl_if.slave  req1,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  state_t              state;
  state_t              state_nxt;
  logic [OP_WIDTH-1:0] op_reg;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [SHW-1:0]      cnt_reg;
  logic [WIDTH-1:0]    res_reg;
  logic                zero_reg;
  logic                owner;
  logic                last_grant;
  logic                grant;
  logic                gnt_valid;
  logic                exec_done;
  logic [OP_WIDTH-1:0] sel_op;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;

  rr_arb2 u_arb (
    .valid0     (req0.valid),
    .valid1     (req1.valid),
    .last_grant (last_grant),
    .grant      (grant),
    .gnt_valid  (gnt_valid)
  );

  assign sel_op = grant ? req1.op : req0.op;
  assign sel_a  = grant ? req1.a  : req0.a;
  assign sel_b  = grant ? req1.b  : req0.b;

  assign req0.ready = (state == ST_IDLE) && gnt_valid && !grant;
  assign req1.ready = (state == ST_IDLE) && gnt_valid &&  grant;

  assign req0.rsp_valid  = (state == ST_RESP) && !owner;
  assign req1.rsp_valid  = (state == ST_RESP) &&  owner;
  assign req0.rsp_result = res_reg;
  assign req1.rsp_result = res_reg;
  assign req0.rsp_zero   = zero_reg;
  assign req1.rsp_zero   = zero_reg;

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and ALU drive; the ALU idles on add 0+0 outside EXEC.
  always_comb begin
    state_nxt = state;
    alu_op    = ALU_ADD;
    alu_a     = '0;
    alu_b     = '0;
    exec_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_srln(op_reg)) begin
          alu_b = b_reg;
          if (cnt_reg == '0) begin
            alu_op    = ALU_OR;
            exec_done = 1'b1;
          end else begin
            alu_op    = ALU_SRL;
            exec_done = (cnt_reg == SHW'(1));
          end
        end else begin
          alu_op    = op_reg[3] ? ALU_ADD : op_reg[2:0];
          alu_a     = a_reg;
          alu_b     = b_reg;
          exec_done = 1'b1;
        end
        if (exec_done) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture, SRLN iteration and result latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      cnt_reg    <= '0;
      res_reg    <= '0;
      zero_reg   <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            op_reg     <= sel_op;
            a_reg      <= sel_a;
            b_reg      <= sel_b;
            cnt_reg    <= sel_a[SHW-1:0];
            owner      <= grant;
            last_grant <= grant;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            res_reg  <= alu_result;
            zero_reg <= alu_zero;
          end else begin
            b_reg   <= alu_result;
            cnt_reg <= cnt_reg - SHW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: directed and random requests from both
// ports, expected responses queued at handshake and checked when they appear.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    int               due;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  int   cyc;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];

  alu_share_ctrl_if #(.WIDTH(WIDTH)) req_port0 ();
  alu_share_ctrl_if #(.WIDTH(WIDTH)) req_port1 ();

  alu_share_ctrl #(.WIDTH(WIDTH), .SHW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req_port0),
    .req1       (req_port1),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  // Combinational single-cycle ALU shared through the controller.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = alu_a ^ alu_b;
      3'b100:  alu_result = ~(alu_a | alu_b);
      3'b101:  alu_result = alu_b >> 1;
      3'b110:  alu_result = alu_a - alu_b;
      default: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: what the requester should get back for a command.
  function automatic logic [WIDTH:0] refModel(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    if (op == 4'b1101) r = b >> a[4:0];
    else if (op[3]) r = a + b;
    else begin
      case (op[2:0])
        3'd0: r = a & b;
        3'd1: r = a | b;
        3'd2: r = a + b;
        3'd3: r = a ^ b;
        3'd4: r = ~(a | b);
        3'd5: r = b >> 1;
        3'd6: r = a - b;
        default: r = (a < b) ? 32'd1 : 32'd0;
      endcase
    end
    return {(r == '0), r};
  endfunction

  // Cycles from handshake to response, not counting the handshake cycle itself.
  function automatic int refLatency(input logic [3:0] op, input logic [WIDTH-1:0] a);
    int n;
    if (op != 4'b1101) return 2;
    n = int'(a[4:0]);
    return 1 + ((n > 1) ? n : 1);
  endfunction

  function automatic exp_t makeExp(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input int now);
    exp_t e;
    logic [WIDTH:0] m;
    m     = refModel(op, a, b);
    e.res = m[WIDTH-1:0];
    e.zero = m[WIDTH];
    e.due = now + refLatency(op, a);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRsp(input int port, input logic [WIDTH-1:0] res, input logic zero);
    exp_t e;
    if ((port == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp%0d_unexpected: got response 0x%0h at cycle %0d expected none", port, res, cyc);
    end else begin
      e = (port == 0) ? q0.pop_front() : q1.pop_front();
      checkOutput($sformatf("rsp%0d_result", port), 64'(res), 64'(e.res));
      checkOutput($sformatf("rsp%0d_zero", port), 64'(zero), 64'(e.zero));
      checkOutput($sformatf("rsp%0d_cycle", port), 64'(cyc), 64'(e.due));
    end
  endtask

  // Scoreboard: queue expectations on handshake, compare on response pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_port0.valid && req_port0.ready) begin
        q0.push_back(makeExp(req_port0.op, req_port0.a, req_port0.b, cyc));
        grant_log.push_back(0);
      end
      if (req_port1.valid && req_port1.ready) begin
        q1.push_back(makeExp(req_port1.op, req_port1.a, req_port1.b, cyc));
        grant_log.push_back(1);
      end
      if (req_port0.ready || req_port1.ready) begin
        checkOutput("single_ready", 64'(req_port0.ready & req_port1.ready), 64'd0);
      end
      if (req_port0.rsp_valid) checkRsp(0, req_port0.rsp_result, req_port0.rsp_zero);
      if (req_port1.rsp_valid) checkRsp(1, req_port1.rsp_result, req_port1.rsp_zero);
    end
  end

  // Present one request and hold it until accepted (bounded wait).
  task automatic applyStimulus(input int port, input logic [3:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    bit done;
    int waited;
    done = 0;
    waited = 0;
    if (port == 0) begin
      req_port0.op = op; req_port0.a = a; req_port0.b = b; req_port0.valid = 1'b1;
    end else begin
      req_port1.op = op; req_port1.a = a; req_port1.b = b; req_port1.valid = 1'b1;
    end
    while (!done && waited < 300) begin
      @(negedge clk);
      if ((port == 0) ? req_port0.ready : req_port1.ready) done = 1;
      else waited++;
    end
    if (done) @(posedge clk);
    else begin
      checks++;
      errors++;
      $display("[TB] FAIL req%0d_accept_timeout: got no ready after %0d cycles expected ready", port, waited);
    end
    #1;
    if (port == 0) req_port0.valid = 1'b0;
    else req_port1.valid = 1'b0;
  endtask

  task automatic waitDrain();
    int waited;
    waited = 0;
    while ((q0.size() != 0 || q1.size() != 0) && waited < 400) begin
      @(posedge clk);
      waited++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready0"}, 64'(req_port0.ready), 64'd0);
    checkOutput({tag, "_ready1"}, 64'(req_port1.ready), 64'd0);
    checkOutput({tag, "_rsp0_valid"}, 64'(req_port0.rsp_valid), 64'd0);
    checkOutput({tag, "_rsp1_valid"}, 64'(req_port1.rsp_valid), 64'd0);
    checkOutput({tag, "_rsp_result"}, 64'(req_port0.rsp_result), 64'd0);
    checkOutput({tag, "_rsp_zero"}, 64'(req_port1.rsp_zero), 64'd0);
    checkOutput({tag, "_alu_op"}, 64'(alu_op), 64'd2);
    checkOutput({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    checkOutput({tag, "_alu_b"}, 64'(alu_b), 64'd0);
  endtask

  function automatic logic [3:0] pickOp();
    int r;
    r = int'($urandom_range(0, 10));
    if (r < 8) return 4'(r);
    if (r < 10) return 4'b1101;
    r = int'($urandom_range(0, 6));
    return (r == 5) ? 4'b1111 : 4'(8 + r);
  endfunction

  task automatic randomPort(input int port, input int count);
    for (int i = 0; i < count; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      applyStimulus(port, pickOp(), $urandom, $urandom);
    end
  endtask

  initial begin
    int start;
    cyc = 0;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req_port0.valid = 1'b0; req_port0.op = '0; req_port0.a = '0; req_port0.b = '0;
    req_port1.valid = 1'b0; req_port1.op = '0; req_port1.a = '0; req_port1.b = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed ALU ops");
    applyStimulus(0, 4'b0010, 32'd5, 32'd7);
    waitDrain();
    checkOutput("add_5_7", 64'(req_port0.rsp_result), 64'd12);
    applyStimulus(1, 4'b0110, 32'd9, 32'd9);
    waitDrain();
    checkOutput("sub_9_9_zero", 64'(req_port1.rsp_zero), 64'd1);
    applyStimulus(1, 4'b0111, 32'd3, 32'hFFFF_FFFF);
    waitDrain();
    checkOutput("slt_unsigned", 64'(req_port1.rsp_result), 64'd1);

    $display("[TB] SRLN and reserved ops");
    applyStimulus(0, 4'b1101, 32'd4, 32'h8000_0000);
    waitDrain();
    checkOutput("srln_4", 64'(req_port0.rsp_result), 64'h0800_0000);
    applyStimulus(0, 4'b1101, 32'd0, 32'hDEAD_BEEF);
    applyStimulus(0, 4'b1101, 32'd32, 32'h1234_5678);
    waitDrain();
    checkOutput("srln_32_count0", 64'(req_port0.rsp_result), 64'h1234_5678);
    applyStimulus(1, 4'b1101, 32'd31, 32'd1);
    applyStimulus(1, 4'b1000, 32'd2, 32'd3);
    waitDrain();
    checkOutput("reserved_add", 64'(req_port1.rsp_result), 64'd5);

    $display("[TB] both requesters continuously valid");
    start = grant_log.size();
    fork
      for (int i = 0; i < 4; i++) applyStimulus(0, 4'b0011, $urandom, $urandom);
      for (int i = 0; i < 4; i++) applyStimulus(1, 4'b0100, $urandom, $urandom);
    join
    waitDrain();
    for (int i = start; i < grant_log.size(); i++) begin
      checkOutput($sformatf("rr_alternate_%0d", i - start), 64'(grant_log[i]), 64'(1 - grant_log[i-1]));
    end

    $display("[TB] random traffic");
    fork
      randomPort(0, 20);
      randomPort(1, 20);
    join
    waitDrain();

    $display("[TB] reset during SRLN");
    applyStimulus(0, 4'b1101, 32'd10, 32'hFFFF_0000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q0.delete();
    #1;
    checkResetState("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("midreset_no_rsp", 64'(req_port0.rsp_result), 64'd0);
    applyStimulus(0, 4'b0010, 32'd100, 32'd23);
    waitDrain();
    checkOutput("post_reset_add", 64'(req_port0.rsp_result), 64'd123);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
